// File: rtl/io_bus_pkg.sv
// Shared pad map, widths and FSM state encoding for the host parallel-bus target.
package io_bus_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int PAD_W    = 24;
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 8;
  localparam int STRB     = 12;
  localparam int RNW      = 13;
  localparam int ACK      = 14;
  localparam int ERR      = 15;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACK,
    RD_WAIT,
    RD_SETUP,
    RD_ACK,
    RELEASE
  } state_t;
endpackage

// File: rtl/io_sync_edge.sv
// Multi-flop synchroniser for the host strobe followed by a single edge-detect flop.
module io_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      s_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~s_d;
  assign fall = ~sync[SYNC_STAGES-1] & s_d;
endmodule

// File: rtl/io_bus_target.sv
// Host-driven 4-phase parallel bus target: decodes reads/writes, hands them to user logic,
// and turns the shared data pins around with a one-cycle setup and release margin.
module io_bus_target
  import io_bus_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter int                RD_TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAD_W-1:0]  io_in,
  output logic [PAD_W-1:0]  io_out,
  output logic [PAD_W-1:0]  io_oeb,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid
);
  state_t              state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic                err, err_n;
  logic [DATA_W-1:0]   rdata, rdata_n;
  logic [ADDR_W-1:0]   rd_addr_n, wr_addr_n;
  logic [DATA_W-1:0]   wr_data_n;
  logic                wr_valid_n;
  logic                rise, fall;
  logic                ack, drive;
  logic [ADDR_W-1:0]   pad_addr;
  logic [DATA_W-1:0]   pad_data;
  logic                unused_pins;

  io_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (io_in[STRB]),
    .rise (rise),
    .fall (fall)
  );

  assign pad_addr    = io_in[ADDR_LSB +: ADDR_W];
  assign pad_data    = io_in[DATA_LSB +: DATA_W];
  assign unused_pins = ^io_in[PAD_W-1:RNW+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      err      <= err_n;
      rdata    <= rdata_n;
      rd_addr  <= rd_addr_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      wr_valid <= wr_valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    err_n      = err;
    rdata_n    = rdata;
    rd_addr_n  = rd_addr;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    wr_valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (io_in[RNW]) begin
            rd_addr_n = pad_addr;
            cnt_n     = '0;
            state_n   = RD_WAIT;
          end else begin
            wr_addr_n  = pad_addr;
            wr_data_n  = pad_data;
            wr_valid_n = 1'b1;
            state_n    = WR_ACK;
          end
        end
      end
      WR_ACK: if (fall) state_n = RELEASE;
      RD_WAIT: begin
        cnt_n = cnt + 8'd1;
        // Host abort wins over a simultaneous user response: the bus is never driven.
        if (fall) begin
          state_n = IDLE;
        end else if (rd_valid) begin
          rdata_n = rd_data;
          state_n = RD_SETUP;
        end else if (cnt == 8'(RD_TIMEOUT - 1)) begin
          rdata_n = ERR_DATA;
          err_n   = 1'b1;
          state_n = RD_SETUP;
        end
      end
      RD_SETUP: state_n = RD_ACK;
      RD_ACK:   if (fall) state_n = RELEASE;
      RELEASE: begin
        err_n   = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode straight from the async-reset state so reset releases the bus immediately.
  assign ack    = (state == WR_ACK) || (state == RD_ACK) || (state == RELEASE);
  assign drive  = (state == RD_SETUP) || (state == RD_ACK);
  assign rd_req = (state == RD_WAIT);

  always_comb begin
    io_out                      = '0;
    io_out[DATA_LSB +: DATA_W]  = drive ? rdata : '0;
    io_out[ACK]                 = ack;
    io_out[ERR]                 = err;
  end

  always_comb begin
    io_oeb                      = '1;
    io_oeb[ACK]                 = 1'b0;
    io_oeb[ERR]                 = 1'b0;
    io_oeb[DATA_LSB +: DATA_W]  = drive ? '0 : '1;
  end
endmodule

// File: tb/tb_io_bus_target.sv
// Directed bench for io_bus_target: write, reads, timeout, abort and async reset mid-read.
module tb_io_bus_target;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] io_in;
  logic [23:0] io_out;
  logic [23:0] io_oeb;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  localparam logic [23:0] OEB_IDLE = 24'hFF3FFF;

  io_bus_target #(.SYNC_STAGES(2), .RD_TIMEOUT(16), .ERR_DATA(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) wr_pulses <= wr_pulses + 1;
    if (mon_en && (io_out[14] || io_oeb[7:0] != 8'hFF)) bad <= bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic r, input logic [3:0] a, input logic [7:0] d);
    io_in = {10'b0, r, s, a, d};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w0;
    int b0;
    int n;
    rst = 1'b1; io_in = '0; rd_valid = 1'b0; rd_data = '0;
    #2;
    chk("rst_out", io_out, 0);
    chk("rst_oeb", io_oeb, OEB_IDLE);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_addrs", {wr_addr, rd_addr, wr_data}, 0);
    step(2);
    rst = 1'b0;
    step(2);

    // write
    w0 = wr_pulses;
    drive(1, 0, 4'h3, 8'hA5);
    step(2);
    chk("wr_ack_early", io_out[14], 0);
    chk("wr_valid_early", wr_valid, 0);
    step(1);
    chk("wr_valid", wr_valid, 1);
    chk("wr_addr", wr_addr, 4'h3);
    chk("wr_data", wr_data, 8'hA5);
    chk("wr_ack", io_out[14], 1);
    chk("wr_oeb", io_oeb, OEB_IDLE);
    step(1);
    chk("wr_valid_pulse", wr_valid, 0);
    drive(0, 0, 4'h3, 8'hA5);
    step(3);
    chk("wr_release_ack", io_out[14], 1);
    chk("wr_release_oeb", io_oeb[7:0], 8'hFF);
    step(1);
    chk("wr_ack_drop", io_out[14], 0);
    step(1);
    chk("wr_pulse_count", wr_pulses - w0, 1);

    // read with same-cycle response
    drive(1, 1, 4'h7, 8'h00);
    step(3);
    chk("rdi_req", rd_req, 1);
    chk("rdi_addr", rd_addr, 4'h7);
    chk("rdi_oeb_wait", io_oeb[7:0], 8'hFF);
    rd_valid = 1'b1; rd_data = 8'h3C;
    step(1);
    rd_valid = 1'b0;
    chk("rdi_req_drop", rd_req, 0);
    chk("rdi_setup_oeb", io_oeb[7:0], 8'h00);
    chk("rdi_setup_data", io_out[7:0], 8'h3C);
    chk("rdi_setup_ack", io_out[14], 0);
    step(1);
    chk("rdi_ack", io_out[14], 1);
    chk("rdi_ack_data", io_out[7:0], 8'h3C);
    drive(0, 1, 4'h7, 8'h00);
    step(3);
    chk("rdi_release_oeb", io_oeb[7:0], 8'hFF);
    chk("rdi_release_data", io_out[7:0], 8'h00);
    chk("rdi_release_ack", io_out[14], 1);
    step(1);
    chk("rdi_ack_drop", io_out[14], 0);

    // read with response after 10 cycles
    drive(1, 1, 4'h9, 8'h00);
    step(3);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step(1);
      chk("rdd_req_held", rd_req, 1);
      chk("rdd_addr_stable", rd_addr, 4'h9);
    end
    rd_valid = 1'b1; rd_data = 8'h5A;
    step(1);
    rd_valid = 1'b0;
    chk("rdd_req_drop", rd_req, 0);
    chk("rdd_data", io_out[7:0], 8'h5A);
    chk("rdd_err", io_out[15], 0);
    step(1);
    chk("rdd_ack", io_out[14], 1);
    drive(0, 1, 4'h9, 8'h00);
    step(4);
    chk("rdd_ack_drop", io_out[14], 0);

    // read timeout
    drive(1, 1, 4'h2, 8'h00);
    step(3);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (!rd_req) break;
      n++;
    end
    chk("to_req_cycles", n, 16);
    chk("to_data", io_out[7:0], 8'hFF);
    chk("to_oeb", io_oeb[7:0], 8'h00);
    chk("to_err", io_out[15], 1);
    chk("to_setup_ack", io_out[14], 0);
    step(1);
    chk("to_ack", io_out[14], 1);
    chk("to_err_ack", io_out[15], 1);
    drive(0, 1, 4'h2, 8'h00);
    step(3);
    chk("to_release_err", io_out[15], 1);
    chk("to_release_oeb", io_oeb[7:0], 8'hFF);
    step(1);
    chk("to_ack_drop", io_out[14], 0);
    chk("to_err_clear", io_out[15], 0);

    // host abort with simultaneous rd_valid
    b0 = bad;
    drive(1, 1, 4'h5, 8'h00);
    step(3);
    chk("ab_req", rd_req, 1);
    mon_en = 1'b1;
    drive(0, 1, 4'h5, 8'h00);
    step(2);
    chk("ab_req_before", rd_req, 1);
    rd_valid = 1'b1; rd_data = 8'h77;
    step(1);
    rd_valid = 1'b0;
    chk("ab_req_drop", rd_req, 0);
    step(3);
    mon_en = 1'b0;
    step(1);
    chk("ab_no_ack_no_drive", bad - b0, 0);
    chk("ab_out_idle", io_out, 0);
    drive(1, 0, 4'hA, 8'h5C);
    step(3);
    chk("ab_wr_valid", wr_valid, 1);
    chk("ab_wr_fields", {wr_addr, wr_data}, {4'hA, 8'h5C});
    chk("ab_wr_ack", io_out[14], 1);
    drive(0, 0, 4'hA, 8'h5C);
    step(4);
    chk("ab_wr_ack_drop", io_out[14], 0);

    // async reset while in RD_ACK
    drive(1, 1, 4'h4, 8'h00);
    step(3);
    rd_valid = 1'b1; rd_data = 8'hC3;
    step(1);
    rd_valid = 1'b0;
    step(1);
    chk("rs_in_rd_ack", io_out[14], 1);
    #2;
    rst = 1'b1; io_in = '0;
    #1;
    chk("rs_ack_async", io_out[14], 0);
    chk("rs_oeb_async", io_oeb, OEB_IDLE);
    chk("rs_out_async", io_out, 0);
    chk("rs_req_async", rd_req, 0);
    step(1);
    rst = 1'b0;
    step(1);
    drive(1, 0, 4'h6, 8'h81);
    step(3);
    chk("rs_wr_valid", wr_valid, 1);
    chk("rs_wr_fields", {wr_addr, wr_data}, {4'h6, 8'h81});
    chk("rs_wr_ack", io_out[14], 1);
    drive(0, 0, 4'h6, 8'h81);
    step(4);
    chk("rs_wr_ack_drop", io_out[14], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_bus_target.md
Name: io_bus_target

Overview:
- User-design slave for a 4-phase, half-duplex parallel bus driven by the board host MCU over the fabric IO pads.
- Sits inside `top` on the user side of the pad wrapper (io_in/io_out/io_oeb, where oeb=1 means pad is input).
- Decodes host read/write transactions, hands them to user logic over a write-strobe port and a read request/valid handshake, and turns the data bus around safely.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for host strobe (≥2).
- RD_TIMEOUT, 255, max cycles waiting for rd_valid before error completion (1..255).
- ERR_DATA, 8'hFF, data returned on read timeout.

Ports:
- clk  in  1  fabric global clock.
- rst  in  1  asynchronous, active-high reset.
- io_in  in  24  pad inputs: [7:0] data from host, [11:8] addr, [12] strb, [13] rnw (1 = read).
- io_out  out  24  pad outputs: [7:0] read data, [14] ack, [15] err; all others 0.
- io_oeb  out  24  pad output enables (1 = input): [7:0] per state; [15:14] always 0; all others always 1.
- wr_valid  out  1  one-cycle pulse: write accepted.
- wr_addr  out  4  write address, valid with wr_valid.
- wr_data  out  8  write data, valid with wr_valid.
- rd_req  out  1  level, held until rd_valid or abort/timeout.
- rd_addr  out  4  read address, stable while rd_req.
- rd_data  in  8  read data, sampled when rd_req & rd_valid.
- rd_valid  in  1  read data available (same-cycle response allowed).

Behaviour:
- Reset values (async, immediate): io_out = 0; io_oeb[23:16] = 1, [15:14] = 0, [13:0] = 1; wr_valid = 0; rd_req = 0; addresses/data = 0; FSM in IDLE; sync flops = 0; timeout counter = 0.
- Strobe handling: strb passes through SYNC_STAGES flops, then one edge-detect flop.
  - rise = s & ~s_d; fall = ~s & s_d.
  - io_in[11:0] and [13] are sampled raw at the edge where rise is acted on. Host holds them stable from before strb rises until ack.
- FSM states:
  - IDLE: on rise with rnw=0, capture addr/data, pulse wr_valid, go to WR_ACK. On rise with rnw=1, capture addr, set rd_req=1, clear counter, go to RD_WAIT.
  - WR_ACK: ack=1. On fall, go to RELEASE.
  - RD_WAIT: rd_req=1, counter increments each cycle.
    - rd_valid: latch rd_data, rd_req=0, io_oeb[7:0]=0, go to RD_SETUP.
    - counter == RD_TIMEOUT-1 without rd_valid: latch ERR_DATA, err=1, same transition.
    - fall (host abort): rd_req=0, go to IDLE; no ack, bus never driven. Abort has priority over rd_valid in the same cycle.
  - RD_SETUP: data driven for exactly one cycle with ack=0 (setup), then go to RD_ACK.
  - RD_ACK: ack=1, data driven. On fall, go to RELEASE.
  - RELEASE: io_oeb[7:0]=1 and io_out[7:0]=0 this cycle; ack stays 1. Next cycle ack=0, err=0, go to IDLE. Guarantees the bus is released one cycle before ack drops.
- Latency, write (SYNC_STAGES=2): wr_valid pulse and ack=1 after the 3rd rising clk edge following strb high at the pad.
- Latency, read with immediate rd_valid: data driven after edge 4, ack after edge 5.
- A rise is only acted on in IDLE. Strobe activity in other states is handled only via fall.
- err is sticky for the transaction; it clears when ack clears.
- Reset mid-transaction: bus released and ack dropped asynchronously; no wr_valid; any pending rd_req dropped.

Decomposition:
- Package io_bus_pkg: pin index constants (DATA_LSB=0, ADDR_LSB=8, STRB=12, RNW=13, ACK=14, ERR=15), FSM state enum, width constants (DATA_W=8, ADDR_W=4).
- One sub-module: io_sync_edge (parameterised SYNC_STAGES synchroniser plus rise/fall detect, async reset).

Test Plan:
- Write: addr=4'h3, data=8'hA5, rnw=0, strb↑ → one wr_valid pulse with wr_addr=3, wr_data=A5 and ack=1 3 cycles after strb. strb↓ → ack=0 after RELEASE; io_oeb[7:0] stays 1 throughout.
- Read, immediate: addr=4'h7, rnw=1, strb↑, user returns rd_valid with rd_data=8'h3C in the same cycle as rd_req → io_oeb[7:0]=0 with io_out[7:0]=3C one cycle before ack=1. strb↓ → oeb[7:0]=1 one cycle before ack=0.
- Read, delayed: rd_valid 10 cycles after rd_req → rd_req held exactly 10 cycles, rd_addr stable, data 8'h5A returned, err=0.
- Timeout: RD_TIMEOUT=16, rd_valid never asserted → after 16 cycles io_out[7:0]=FF, err=1, ack=1. err=0 after the handshake completes.
- Abort: strb↓ while in RD_WAIT, with rd_valid asserted the same cycle → rd_req=0, ack never asserts, oeb[7:0] never 0, FSM back to IDLE; the next write completes normally.
- Async reset asserted in RD_ACK → ack=0, io_oeb[7:0]=1 immediately (without waiting for a clock edge); after release, a write transaction completes normally.
